bmf_approx_pipe: RTL and testbench

//  Parametrised, pipelined successor to the fixed k=6 BMF decompressor of the buttfly partitions.
//  - Rebuilds an approximate output word as the Boolean product of a K-bit factor vector and a
//    run-time programmable KxN_OUT basis matrix H.
//  - Selects exact or approximate output per transaction.
//  - Accumulates error statistics against the exact word.
//  - Sits between a partition's compressor/exact logic and the downstream datapath.

---
 rtl/bmf_approx_pipe.sv | 181 ++++++++++++++++++
 tb/tb_bmf_approx_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bmf_approx_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bmf_approx_pipe
// Description : Two-stage pipelined BMF decompressor. It rebuilds the
//               approximate word as the Boolean product of the factor vector
//               and a programmable basis H, selects the exact or approximate
//               word, and keeps saturating error statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module bmf_approx_pipe #(
    parameter int K     = 6,
    parameter int N_OUT = 10,
    parameter int CNT_W = 32,
    parameter int ROW_W = 3,
    parameter int HD_W  = $clog2(N_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [ROW_W-1:0] cfg_row,
    input  logic [N_OUT-1:0] cfg_data,
    input  logic             mode,
    input  logic             clr_stats,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_k,
    input  logic [N_OUT-1:0] in_exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    output logic [HD_W-1:0]  out_hd,
    output logic [CNT_W-1:0] err_bits,
    output logic [CNT_W-1:0] err_words,
    output logic [HD_W-1:0]  max_hd
);

    logic [N_OUT-1:0] h_q [K];
    logic [N_OUT-1:0] h_d [K];

    logic             s1_v_q, s1_v_d;
    logic [N_OUT-1:0] s1_approx_q, s1_approx_d;
    logic [N_OUT-1:0] s1_exact_q, s1_exact_d;
    logic [HD_W-1:0]  s1_hd_q, s1_hd_d;
    logic             s1_mode_q, s1_mode_d;

    logic             s2_v_q, s2_v_d;
    logic [N_OUT-1:0] out_data_q, out_data_d;
    logic [HD_W-1:0]  out_hd_q, out_hd_d;

    logic [CNT_W-1:0] err_bits_q, err_bits_d;
    logic [CNT_W-1:0] err_words_q, err_words_d;
    logic [HD_W-1:0]  max_hd_q, max_hd_d;

    logic [N_OUT-1:0] w_approx;
    logic [N_OUT-1:0] w_diff;
    logic [HD_W-1:0]  w_hd;
    logic             w_in_fire;
    logic             w_s2_adv;
    logic [CNT_W:0]   w_bits_sum;

    assign in_ready  = !s1_v_q || !s2_v_q || out_ready;
    assign w_in_fire = in_valid && in_ready;
    assign w_s2_adv  = s1_v_q && (!s2_v_q || out_ready);

    assign out_valid = s2_v_q;
    assign out_data  = out_data_q;
    assign out_hd    = out_hd_q;
    assign err_bits  = err_bits_q;
    assign err_words = err_words_q;
    assign max_hd    = max_hd_q;

    // Rows outside 0..K-1 match no index and are silently dropped.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            h_d[i] = h_q[i];
            if (cfg_we && (cfg_row == ROW_W'(i))) begin
                h_d[i] = cfg_data;
            end
        end
    end

    // Reads the registered H, so a same-cycle write only affects later words.
    always_comb begin
        w_approx = '0;
        for (int i = 0; i < K; i++) begin
            if (in_k[i]) begin
                w_approx = w_approx | h_q[i];
            end
        end
        w_diff = w_approx ^ in_exact;
        w_hd   = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_hd = w_hd + HD_W'(w_diff[j]);
        end
    end

    always_comb begin
        s1_v_d      = s1_v_q;
        s1_approx_d = s1_approx_q;
        s1_exact_d  = s1_exact_q;
        s1_hd_d     = s1_hd_q;
        s1_mode_d   = s1_mode_q;
        if (w_in_fire) begin
            s1_v_d      = 1'b1;
            s1_approx_d = w_approx;
            s1_exact_d  = in_exact;
            s1_hd_d     = w_hd;
            s1_mode_d   = mode;
        end else if (w_s2_adv) begin
            s1_v_d = 1'b0;
        end

        s2_v_d     = s2_v_q;
        out_data_d = out_data_q;
        out_hd_d   = out_hd_q;
        if (w_s2_adv) begin
            s2_v_d     = 1'b1;
            out_data_d = s1_mode_q ? s1_approx_q : s1_exact_q;
            out_hd_d   = s1_hd_q;
        end else if (out_ready) begin
            s2_v_d = 1'b0;
        end
    end

    // Statistics follow words into S2; a clear in the same cycle takes priority.
    always_comb begin
        err_bits_d  = err_bits_q;
        err_words_d = err_words_q;
        max_hd_d    = max_hd_q;
        w_bits_sum  = {1'b0, err_bits_q} + (CNT_W + 1)'(s1_hd_q);
        if (clr_stats) begin
            err_bits_d  = '0;
            err_words_d = '0;
            max_hd_d    = '0;
        end else if (w_s2_adv) begin
            err_bits_d = w_bits_sum[CNT_W] ? '1 : w_bits_sum[CNT_W-1:0];
            if ((s1_hd_q != '0) && (err_words_q != '1)) begin
                err_words_d = err_words_q + CNT_W'(1);
            end
            if (s1_hd_q > max_hd_q) begin
                max_hd_d = s1_hd_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                h_q[i] <= '0;
            end
            s1_v_q      <= 1'b0;
            s1_approx_q <= '0;
            s1_exact_q  <= '0;
            s1_hd_q     <= '0;
            s1_mode_q   <= 1'b0;
            s2_v_q      <= 1'b0;
            out_data_q  <= '0;
            out_hd_q    <= '0;
            err_bits_q  <= '0;
            err_words_q <= '0;
            max_hd_q    <= '0;
        end else begin
            for (int i = 0; i < K; i++) begin
                h_q[i] <= h_d[i];
            end
            s1_v_q      <= s1_v_d;
            s1_approx_q <= s1_approx_d;
            s1_exact_q  <= s1_exact_d;
            s1_hd_q     <= s1_hd_d;
            s1_mode_q   <= s1_mode_d;
            s2_v_q      <= s2_v_d;
            out_data_q  <= out_data_d;
            out_hd_q    <= out_hd_d;
            err_bits_q  <= err_bits_d;
            err_words_q <= err_words_d;
            max_hd_q    <= max_hd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bmf_approx_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmf_approx_pipe
// Description : Directed scoreboard bench for bmf_approx_pipe (CNT_W = 4 so
//               counter saturation is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bmf_approx_pipe;

    localparam int K     = 6;
    localparam int N_OUT = 10;
    localparam int CNT_W = 4;
    localparam int ROW_W = 3;
    localparam int HD_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [ROW_W-1:0] cfg_row;
    logic [N_OUT-1:0] cfg_data;
    logic             mode;
    logic             clr_stats;
    logic             in_valid;
    logic             in_ready;
    logic [K-1:0]     in_k;
    logic [N_OUT-1:0] in_exact;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_data;
    logic [HD_W-1:0]  out_hd;
    logic [CNT_W-1:0] err_bits;
    logic [CNT_W-1:0] err_words;
    logic [HD_W-1:0]  max_hd;

    int checks = 0;
    int errors = 0;
    logic [N_OUT+HD_W-1:0] sb [$];
    logic [N_OUT+HD_W-1:0] mon_e;

    bmf_approx_pipe #(
        .K(K), .N_OUT(N_OUT), .CNT_W(CNT_W), .ROW_W(ROW_W), .HD_W(HD_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row),
        .cfg_data(cfg_data), .mode(mode), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready), .in_k(in_k),
        .in_exact(in_exact), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_hd(out_hd), .err_bits(err_bits),
        .err_words(err_words), .max_hd(max_hd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake pops the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data %0h with none outstanding", out_data);
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", out_data, mon_e[N_OUT+HD_W-1:HD_W]);
                chk("out_hd", out_hd, mon_e[HD_W-1:0]);
            end
        end
    end

    task automatic send(input logic [K-1:0] k, input logic [N_OUT-1:0] ex, input logic m,
                        input logic [N_OUT-1:0] ed, input logic [HD_W-1:0] eh);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_k     = k;
        in_exact = ex;
        mode     = m;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end else begin
            sb.push_back({ed, eh});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic cfg_write(input logic [ROW_W-1:0] row, input logic [N_OUT-1:0] data);
        cfg_we   = 1'b1;
        cfg_row  = row;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string tag, input int eb, input int ew, input int mh);
        chk({tag, "_err_bits"}, err_bits, eb);
        chk({tag, "_err_words"}, err_words, ew);
        chk({tag, "_max_hd"}, max_hd, mh);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_row = '0; cfg_data = '0; mode = 1'b0;
        clr_stats = 1'b0; in_valid = 1'b0; in_k = '0; in_exact = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_hd", out_hd, 0);
        chk_stats("rst", 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 1);

        // Identity basis, approximate mode, with latency check
        for (int i = 0; i < K; i++) cfg_write(ROW_W'(i), N_OUT'(1) << i);
        send(6'b101101, 10'h02D, 1'b1, 10'h02D, 4'd0);
        @(negedge clk);
        chk("lat_cycle1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid, 1);
        drain();
        chk_stats("ident", 0, 0, 0);

        // OR merge of two rows, exact mode
        clear_stats();
        cfg_write(3'd0, 10'h003);
        cfg_write(3'd1, 10'h006);
        send(6'b000011, 10'h000, 1'b0, 10'h000, 4'd3);
        drain();
        chk_stats("ormerge", 3, 1, 3);

        // Row 0 rewritten in the accept cycle: first word sees old row
        cfg_we = 1'b1; cfg_row = 3'd0; cfg_data = 10'h300;
        send(6'b000001, 10'h000, 1'b1, 10'h003, 4'd2);
        send(6'b000001, 10'h000, 1'b1, 10'h300, 4'd2);
        drain();
        chk_stats("race", 7, 3, 3);

        // Backpressure: five words with the sink stalled
        clear_stats();
        out_ready = 1'b0;
        fork
            begin
                send(6'b000100, 10'h004, 1'b1, 10'h004, 4'd0);
                send(6'b001000, 10'h000, 1'b1, 10'h008, 4'd1);
                send(6'b010000, 10'h010, 1'b1, 10'h010, 4'd0);
                send(6'b100000, 10'h021, 1'b1, 10'h020, 4'd1);
                send(6'b000010, 10'h006, 1'b1, 10'h006, 4'd0);
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_ready_a", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_hold_data_a", out_data, 10'h004);
                @(negedge clk);
                chk("bp_in_ready_b", in_ready, 0);
                chk("bp_hold_data_b", out_data, 10'h004);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_all_delivered", sb.size(), 0);
        chk_stats("bp", 2, 2, 1);

        // Saturation: 20 words of hd=1 into 4-bit counters
        clear_stats();
        repeat (20) send(6'b000100, 10'h000, 1'b0, 10'h000, 4'd1);
        drain();
        chk_stats("sat", 15, 15, 1);
        send(6'b000100, 10'h000, 1'b0, 10'h000, 4'd1);
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        drain();
        chk_stats("clr_wins", 0, 0, 0);

        // Asynchronous reset with two words in flight
        out_ready = 1'b0;
        send(6'b000100, 10'h000, 1'b1, 10'h004, 4'd1);
        send(6'b000100, 10'h000, 1'b1, 10'h004, 4'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk_stats("mid_rst", 0, 0, 0);
        sb.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(6'b111111, 10'h000, 1'b1, 10'h000, 4'd0);
        drain();
        chk_stats("post_rst", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
